result_broadcast: RTL and testbench

- Completion-side counterpart to the reservation station's wakeup logic.
- Collects finished results from the three functional units (FU0 = ALU0, FU1 = ALU1, FU2 = LSU) into per-FU result queues.
- Arbitrates the queued results onto the two registered broadcast buses, bus0 and bus1. The reservation station and the ROB snoop these buses to capture data and mark entries ready.
- Reports per-FU readiness so the issue logic can stall a unit whose result queue is full.

---
 rtl/result_broadcast.sv | 159 +++++++++++++++
 tb/tb_result_broadcast.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_broadcast.sv
// Result broadcast: per-FU completion queues feeding two registered wakeup buses.
// Queues are drained round-robin so no functional unit starves the others.

module rb_fu_queue #(
   parameter int W      = 44,
   parameter int QDEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push_req,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [QDEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]            wptr, rptr;
   logic [CW-1:0]            count;
   logic                     push, pop_ok;

   assign full   = (count == CW'(QDEPTH));
   assign empty  = (count == '0);
   assign head   = mem[rptr];
   // Full/empty decisions use the pre-edge count, so a full queue drops even if it pops now.
   assign push   = push_req & ~full & ~flush;
   assign pop_ok = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)   wptr <= wptr + 1'b1;
         if (pop_ok) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end
endmodule

module result_broadcast #(
   parameter int PREG_WIDTH = 6,
   parameter int ROB_WIDTH  = 6,
   parameter int QDEPTH     = 4,
   parameter int BUS_WIDTH  = 1 + PREG_WIDTH + 32 + ROB_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [2:0]            res_valid,
   input  logic [PREG_WIDTH-1:0] res_rd0,
   input  logic [PREG_WIDTH-1:0] res_rd1,
   input  logic [PREG_WIDTH-1:0] res_rd2,
   input  logic [31:0]           res_data0,
   input  logic [31:0]           res_data1,
   input  logic [31:0]           res_data2,
   input  logic [ROB_WIDTH-1:0]  res_rob0,
   input  logic [ROB_WIDTH-1:0]  res_rob1,
   input  logic [ROB_WIDTH-1:0]  res_rob2,
   output logic [2:0]            fu_ready,
   output logic [BUS_WIDTH-1:0]  bus0,
   output logic [BUS_WIDTH-1:0]  bus1,
   output logic                  overflow
);
   localparam int NFU = 3;

   typedef struct packed {
      logic [PREG_WIDTH-1:0] rd;
      logic [31:0]           data;
      logic [ROB_WIDTH-1:0]  rob;
   } res_t;

   res_t [NFU-1:0]   ent_in, head;
   logic [NFU-1:0]   full, empty, pop;
   logic             g0_v, g1_v;
   logic [1:0]       g0_idx, g1_idx, idx, rr, rr_nxt;

   function automatic logic [1:0] mod3_inc(input logic [1:0] a);
      return (a == 2'd2) ? 2'd0 : a + 2'd1;
   endfunction

   assign ent_in[0] = {res_rd0, res_data0, res_rob0};
   assign ent_in[1] = {res_rd1, res_data1, res_rob1};
   assign ent_in[2] = {res_rd2, res_data2, res_rob2};

   for (genvar i = 0; i < NFU; i++) begin : g_q
      rb_fu_queue #(.W($bits(res_t)), .QDEPTH(QDEPTH)) u_q (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .push_req (res_valid[i]),
         .push_data(ent_in[i]),
         .pop      (pop[i]),
         .head     (head[i]),
         .full     (full[i]),
         .empty    (empty[i])
      );
   end

   assign fu_ready = ~full;

   // Scan rr, rr+1, rr+2: first non-empty queue wins bus0, second wins bus1.
   always_comb begin
      g0_v   = 1'b0;
      g1_v   = 1'b0;
      g0_idx = '0;
      g1_idx = '0;
      pop    = '0;
      idx    = rr;
      for (int k = 0; k < NFU; k++) begin
         if (!empty[idx]) begin
            if (!g0_v) begin
               g0_v   = 1'b1;
               g0_idx = idx;
            end else if (!g1_v) begin
               g1_v   = 1'b1;
               g1_idx = idx;
            end
         end
         idx = mod3_inc(idx);
      end
      if (g0_v) pop[g0_idx] = 1'b1;
      if (g1_v) pop[g1_idx] = 1'b1;
      rr_nxt = rr;
      if (g1_v)      rr_nxt = mod3_inc(g1_idx);
      else if (g0_v) rr_nxt = mod3_inc(g0_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus0     <= '0;
         bus1     <= '0;
         rr       <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         bus0 <= '0;
         bus1 <= '0;
         rr   <= '0;
      end else begin
         bus0 <= g0_v ? {1'b1, head[g0_idx]} : '0;
         bus1 <= g1_v ? {1'b1, head[g1_idx]} : '0;
         rr   <= rr_nxt;
         if (|(res_valid & full)) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_result_broadcast.sv
// Directed bench for result_broadcast: hand-derived bus contents, readiness and overflow.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.

module tb_result_broadcast;
   localparam int BW = 45;

   logic          clk = 1'b0;
   logic          rst_n, flush;
   logic [2:0]    res_valid;
   logic [5:0]    res_rd0, res_rd1, res_rd2;
   logic [31:0]   res_data0, res_data1, res_data2;
   logic [5:0]    res_rob0, res_rob1, res_rob2;
   logic [2:0]    fu_ready;
   logic [BW-1:0] bus0, bus1;
   logic          overflow;

   int n_assert = 0;
   int n_fail   = 0;

   result_broadcast dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .res_valid(res_valid),
      .res_rd0(res_rd0), .res_rd1(res_rd1), .res_rd2(res_rd2),
      .res_data0(res_data0), .res_data1(res_data1), .res_data2(res_data2),
      .res_rob0(res_rob0), .res_rob1(res_rob1), .res_rob2(res_rob2),
      .fu_ready(fu_ready), .bus0(bus0), .bus1(bus1), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk(input logic [5:0] rd, input logic [31:0] d, input logic [5:0] rob);
      return {1'b1, rd, d, rob};
   endfunction

   // Traffic entry for cycle c, FU f is coded as rd = c*4+f.
   function automatic logic [BW-1:0] tv(input int code);
      return mk(6'(code), 32'hC0DE_0000 + 32'(code), 6'(63 - code));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fu(input int fu, input logic [5:0] rd, input logic [31:0] d, input logic [5:0] rob);
      case (fu)
         0: begin res_rd0 = rd; res_data0 = d; res_rob0 = rob; end
         1: begin res_rd1 = rd; res_data1 = d; res_rob1 = rob; end
         default: begin res_rd2 = rd; res_data2 = d; res_rob2 = rob; end
      endcase
   endtask

   task automatic set_traffic(input int c);
      res_valid = 3'b111;
      for (int f = 0; f < 3; f++) set_fu(f, 6'(c*4+f), 32'hC0DE_0000 + 32'(c*4+f), 6'(63 - (c*4+f)));
   endtask

   // All three FUs push every cycle for ncyc cycles, starting idle with rr=0.
   // Expected broadcast order is arrival order (cycle, then FU), two per bus cycle,
   // minus the FU2 entry of cycle drop_c which reaches a full queue.
   task automatic run_traffic(input int ncyc, input int drop_c, input string nm);
      int q[$];
      int last_t;
      int i0;
      logic [2:0] rdy_exp;
      logic       ovf_exp;
      for (int c = 0; c < ncyc; c++)
         for (int f = 0; f < 3; f++)
            if (!(c == drop_c && f == 2)) q.push_back(c*4+f);
      last_t = 2 + (q.size() + 1) / 2;
      for (int t = 0; t <= last_t; t++) begin
         i0 = 2 * (t - 2);
         if (t >= 2 && i0 < q.size())     chk($sformatf("%s bus0 t%0d", nm, t), 64'(bus0), 64'(tv(q[i0])));
         else                             chk($sformatf("%s bus0 t%0d", nm, t), 64'(bus0), 64'd0);
         if (t >= 2 && i0 + 1 < q.size()) chk($sformatf("%s bus1 t%0d", nm, t), 64'(bus1), 64'(tv(q[i0+1])));
         else                             chk($sformatf("%s bus1 t%0d", nm, t), 64'(bus1), 64'd0);
         rdy_exp = 3'b111;
         if (ncyc == 9 && t == 8) rdy_exp = 3'b011;
         if (ncyc == 9 && t == 9) rdy_exp = 3'b101;
         chk($sformatf("%s fu_ready t%0d", nm, t), 64'(fu_ready), 64'(rdy_exp));
         ovf_exp = (drop_c >= 0) && (t >= drop_c + 1);
         chk($sformatf("%s overflow t%0d", nm, t), 64'(overflow), 64'(ovf_exp));
         if (t < ncyc) set_traffic(t);
         else          res_valid = 3'b000;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; res_valid = 3'b000;
      for (int f = 0; f < 3; f++) set_fu(f, 6'd0, 32'd0, 6'd0);
      #3;
      chk("reset bus0", 64'(bus0), 64'd0);
      chk("reset bus1", 64'(bus1), 64'd0);
      chk("reset fu_ready", 64'(fu_ready), 64'd7);
      chk("reset overflow", 64'(overflow), 64'd0);
      #9 rst_n = 1'b1;
      step();

      // Single result, one-cycle latency, shown for exactly one cycle
      res_valid = 3'b001;
      set_fu(0, 6'd5, 32'hDEAD_BEEF, 6'd3);
      step();
      res_valid = 3'b000;
      chk("single no bypass", 64'(bus0), 64'd0);
      step();
      chk("single bus0", 64'(bus0), 64'(mk(6'd5, 32'hDEAD_BEEF, 6'd3)));
      chk("single bus1", 64'(bus1), 64'd0);
      step();
      chk("single bus0 gone", 64'(bus0), 64'd0);

      // rr is 1 here; a flush brings it back to 0
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush0 fu_ready", 64'(fu_ready), 64'd7);

      // Three simultaneous results
      res_valid = 3'b111;
      set_fu(0, 6'd1, 32'h10, 6'd1);
      set_fu(1, 6'd2, 32'h20, 6'd2);
      set_fu(2, 6'd3, 32'h30, 6'd3);
      step();
      res_valid = 3'b000;
      chk("tri idle", 64'(bus0), 64'd0);
      step();
      chk("tri bus0 rd1", 64'(bus0), 64'(mk(6'd1, 32'h10, 6'd1)));
      chk("tri bus1 rd2", 64'(bus1), 64'(mk(6'd2, 32'h20, 6'd2)));
      step();
      chk("tri bus0 rd3", 64'(bus0), 64'(mk(6'd3, 32'h30, 6'd3)));
      chk("tri bus1 none", 64'(bus1), 64'd0);
      step();
      chk("tri drained", 64'(bus0 | bus1), 64'd0);

      // Round-robin fairness, then queue-full with a same-edge pop and drop
      run_traffic(6, -1, "rr");
      run_traffic(9, 8, "full");

      // Flush discards a queued result and the same-edge arrivals
      res_valid = 3'b001;
      set_fu(0, 6'd9, 32'h1111_0001, 6'd9);
      step();
      flush = 1'b1;
      res_valid = 3'b111;
      set_fu(0, 6'd10, 32'h2222_0000, 6'd10);
      set_fu(1, 6'd11, 32'h2222_0001, 6'd11);
      set_fu(2, 6'd12, 32'h2222_0002, 6'd12);
      step();
      flush = 1'b0;
      res_valid = 3'b000;
      chk("flush bus0", 64'(bus0), 64'd0);
      chk("flush bus1", 64'(bus1), 64'd0);
      chk("flush fu_ready", 64'(fu_ready), 64'd7);
      chk("flush keeps overflow", 64'(overflow), 64'd1);
      step();
      chk("flush later bus0", 64'(bus0 | bus1), 64'd0);
      step();
      chk("flush later2 bus", 64'(bus0 | bus1), 64'd0);

      // rr was 2 before the flush; after it FU0 must win bus0
      res_valid = 3'b111;
      set_fu(0, 6'h21, 32'h3333_0000, 6'h21);
      set_fu(1, 6'h22, 32'h3333_0001, 6'h22);
      set_fu(2, 6'h23, 32'h3333_0002, 6'h23);
      step();
      res_valid = 3'b000;
      step();
      chk("post-flush bus0", 64'(bus0), 64'(mk(6'h21, 32'h3333_0000, 6'h21)));
      chk("post-flush bus1", 64'(bus1), 64'(mk(6'h22, 32'h3333_0001, 6'h22)));
      step();
      chk("post-flush bus0 b", 64'(bus0), 64'(mk(6'h23, 32'h3333_0002, 6'h23)));
      chk("post-flush bus1 b", 64'(bus1), 64'd0);

      // Asynchronous reset between edges while FU2 still holds a result
      res_valid = 3'b111;
      set_fu(0, 6'h31, 32'h4444_0000, 6'h31);
      set_fu(1, 6'h32, 32'h4444_0001, 6'h32);
      set_fu(2, 6'h33, 32'h4444_0002, 6'h33);
      step();
      res_valid = 3'b000;
      step();
      chk("pre-reset bus0", 64'(bus0), 64'(mk(6'h31, 32'h4444_0000, 6'h31)));
      #2 rst_n = 1'b0;
      #1;
      chk("async bus0", 64'(bus0), 64'd0);
      chk("async bus1", 64'(bus1), 64'd0);
      chk("async fu_ready", 64'(fu_ready), 64'd7);
      chk("async overflow", 64'(overflow), 64'd0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("no stale bus0 %0d", i), 64'(bus0), 64'd0);
         chk($sformatf("no stale bus1 %0d", i), 64'(bus1), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
